rename_map: RTL and testbench
=============================

Name: rename_map

Overview:
- Rename stage that sits directly upstream of the physical-register free list.
- Translates decoded architectural registers to physical registers (PRs) and allocates a new PR for each destination from the free list.
- Returns superseded PRs to the free list at commit, and drives the free list's rollback mask on a mispredict.
- Holds a speculative map, a retirement map and an in-flight PR bitmap; one instruction per cycle through a registered output stage.

Parameters:
N_AR, 32, number of architectural registers; AR_W = $clog2(N_AR)
N_PR, 64, number of physical registers, equal to `PHYS_REG_SZ; PR_W = $clog2(N_PR), equal to `PHYS_REG_IDX_SZ+1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts an instruction this cycle
in_has_dest  in  1  instruction writes a destination
in_dest_ar  in  AR_W  destination architectural register
in_src1_ar  in  AR_W  source 1 architectural register
in_src2_ar  in  AR_W  source 2 architectural register
out_valid  out  1  renamed instruction valid
out_ready  in  1  downstream accepts
out_has_dest  out  1  allocation performed (in_has_dest && in_dest_ar!=0)
out_dest_pr  out  PR_W  newly allocated PR; 0 if no allocation
out_old_pr  out  PR_W  previous speculative mapping of the destination
out_src1_pr  out  PR_W  source 1 PR
out_src2_pr  out  PR_W  source 2 PR
cm_valid  in  1  commit of one instruction
cm_has_dest  in  1  committed instruction allocated a PR
cm_dest_ar  in  AR_W  committed destination architectural register
cm_dest_pr  in  PR_W  committed new PR
rollback  in  1  mispredict; squash all uncommitted state
fl_is_empty  in  1  free list empty
fl_dequeue_pr  in  PR_W  free list head PR
fl_dequeue_en  out  1  consume fl_dequeue_pr
fl_enqueue_en  out  1  return a PR to the free list
fl_enqueue_pr  out  PR_W  PR being returned
fl_rollback  out  1  free-list rollback strobe
fl_rollback_mask  out  N_PR  PRs to mark free on rollback

Behaviour:
- Reset:
  - All speculative and retirement map entries = 0 (PR 0 is the initial/zero register; the free list never hands out PR 0).
  - In-flight bitmap = 0; out_valid = 0; all out_* = 0.
  - fl_* strobes are combinational and therefore 0 while reset is held.
- alloc = in_valid && in_ready && in_has_dest && in_dest_ar != 0.
  - Architectural register 0 is never renamed and always maps to PR 0.
- in_ready = (!out_valid || out_ready) && !rollback && (!fl_is_empty || fl_enqueue_en).
  - The stall is uniform: it applies even when the instruction has no destination.
  - The fl_enqueue_en term covers the free list passthrough case.
  - in_ready is combinational from those inputs only; it does not depend on in_valid.
- fl_dequeue_en = alloc. On alloc, the new PR is fl_dequeue_pr.
- Latency is 1 cycle. On accept, the output register loads:
  - sources looked up in the speculative map before this instruction's own destination update, so src == dest yields the old PR;
  - out_old_pr = spec_map[in_dest_ar];
  - spec_map[in_dest_ar] <= new PR;
  - inflight[new PR] <= 1.
- out_valid holds with stable payload while !out_ready.
  - out_valid clears when out_ready is high and nothing is accepted in the same cycle.
- A back-to-back dependent instruction sees the updated map next cycle. No intra-cycle bypass is needed at one instruction per cycle.
- Commit with cm_valid && cm_has_dest && cm_dest_ar != 0:
  - old = ret_map[cm_dest_ar]; ret_map[cm_dest_ar] <= cm_dest_pr; inflight[cm_dest_pr] <= 0.
  - fl_enqueue_en = (old != 0) && !rollback; fl_enqueue_pr = old.
  - A commit with no destination has no effect.
- Rename and commit in the same cycle are independent; the allocated PR and cm_dest_pr are always distinct.
- Rollback is combinational to the free list and registered internally in the same cycle:
  - fl_rollback = rollback.
  - fl_rollback_mask = inflight, with bit cm_dest_pr cleared and bit old set when a same-cycle commit with destination and old != 0 occurs. The free list ignores enqueue during rollback, so old is freed through the mask instead.
  - No allocation: in_ready is 0.
  - Next state: spec_map <= ret_map (including the same-cycle commit update); inflight <= 0; out_valid <= 0.
- Reset mid-operation overrides rollback, commit and rename; all state returns to reset values.
- Map registers are written only on clk edges. There are no X outputs after reset.

Test Plan:
- Reset, then rename add r3 <= r1,r2 with fl_dequeue_pr=5 -> fl_dequeue_en=1 that cycle; next cycle out_valid=1, dest_pr=5, old_pr=0, src1_pr=0, src2_pr=0.
- Then rename r4 <= r3,r3 with fl_dequeue_pr=6 -> next cycle src1_pr=5, src2_pr=5, dest_pr=6. Then rename r3 <= r3 with fl_dequeue_pr=7 -> src1_pr=5, old_pr=5, dest_pr=7.
- fl_is_empty=1, cm_valid=0, in_valid=1 -> in_ready=0, fl_dequeue_en=0. Add commit r2<-PR9 where ret_map[r2]=8 -> fl_enqueue_en=1, fl_enqueue_pr=8, in_ready=1 (passthrough).
- Hold out_ready=0 for 3 cycles with a valid output -> payload stable, in_ready=0, no dequeues. Release -> the next instruction is accepted in that cycle.
- Allocate PRs 5, 6, 7, then rollback in the same cycle as commit of r3<-5 (old ret PR 0) -> fl_rollback=1, mask bits {6,7} only. Next cycle spec_map[r3]=5, out_valid=0.
- Rename r0 <= r1 with in_has_dest=1 -> fl_dequeue_en=0, out_has_dest=0, dest_pr=0. Reset asserted mid-stream -> out_valid=0 and all maps=0 next cycle.

Source files
------------

// File: rtl/rename_map.sv
// rename_map: register rename stage in front of the physical-register free list.
//
// Translates the architectural source/destination registers of one decoded
// instruction per cycle into physical registers (PRs), allocating a fresh PR
// from the free list for every real destination. A retirement map tracks the
// committed state; superseded PRs go back to the free list at commit, and on a
// mispredict the speculative map is restored from the retirement map while the
// free list is told which PRs to reclaim.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_*                       decoded instruction (valid/ready handshake)
//   out_*                      renamed instruction, registered, valid/ready
//   cm_*                       commit of one instruction
//   rollback                   mispredict: squash all uncommitted state
//   fl_is_empty, fl_dequeue_pr free-list status and head PR
//   fl_dequeue_en              consume the head PR
//   fl_enqueue_en/pr           return a superseded PR
//   fl_rollback, _mask         rollback strobe and PRs to mark free
module rename_map #(
    parameter int N_AR = 32,
    parameter int N_PR = 64,
    localparam int AR_W = $clog2(N_AR),
    localparam int PR_W = $clog2(N_PR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_has_dest,
    input  logic [AR_W-1:0] in_dest_ar,
    input  logic [AR_W-1:0] in_src1_ar,
    input  logic [AR_W-1:0] in_src2_ar,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_has_dest,
    output logic [PR_W-1:0] out_dest_pr,
    output logic [PR_W-1:0] out_old_pr,
    output logic [PR_W-1:0] out_src1_pr,
    output logic [PR_W-1:0] out_src2_pr,
    input  logic            cm_valid,
    input  logic            cm_has_dest,
    input  logic [AR_W-1:0] cm_dest_ar,
    input  logic [PR_W-1:0] cm_dest_pr,
    input  logic            rollback,
    input  logic            fl_is_empty,
    input  logic [PR_W-1:0] fl_dequeue_pr,
    output logic            fl_dequeue_en,
    output logic            fl_enqueue_en,
    output logic [PR_W-1:0] fl_enqueue_pr,
    output logic            fl_rollback,
    output logic [N_PR-1:0] fl_rollback_mask
);

    // Maps need three reads plus a whole-array copy per cycle, so they are
    // flop arrays rather than block RAM.
    logic [PR_W-1:0] spec_map_reg [N_AR];
    logic [PR_W-1:0] ret_map_reg  [N_AR];
    logic [PR_W-1:0] ret_map_next [N_AR];
    logic [N_PR-1:0] inflight_reg;

    logic            out_valid_reg;
    logic            out_has_dest_reg;
    logic [PR_W-1:0] out_dest_pr_reg;
    logic [PR_W-1:0] out_old_pr_reg;
    logic [PR_W-1:0] out_src1_pr_reg;
    logic [PR_W-1:0] out_src2_pr_reg;

    logic            cm_fire;
    logic [PR_W-1:0] cm_old_pr;
    logic            enq;
    logic            accept;
    logic            alloc;
    logic [N_PR-1:0] mask_next;

    assign cm_fire   = cm_valid && cm_has_dest && (cm_dest_ar != '0);
    assign cm_old_pr = ret_map_reg[cm_dest_ar];
    assign enq       = cm_fire && (cm_old_pr != '0) && !rollback && !reset;

    // A PR freed by commit this cycle can be handed straight back out, so an
    // empty free list does not stall when an enqueue is happening.
    assign in_ready = (!out_valid_reg || out_ready) && !rollback && (!fl_is_empty || enq);
    assign accept   = in_valid && in_ready && !reset;
    assign alloc    = accept && in_has_dest && (in_dest_ar != '0);

    assign fl_dequeue_en = alloc;
    assign fl_enqueue_en = enq;
    assign fl_enqueue_pr = enq ? cm_old_pr : '0;
    assign fl_rollback   = rollback && !reset;

    // The free list drops enqueues during rollback, so a PR superseded by a
    // same-cycle commit is reclaimed through the mask instead; the PR being
    // committed becomes architectural and must stay allocated.
    always_comb begin
        mask_next = inflight_reg;
        if (cm_fire) begin
            mask_next[cm_dest_pr] = 1'b0;
            if (cm_old_pr != '0) begin
                mask_next[cm_old_pr] = 1'b1;
            end
        end
        fl_rollback_mask = reset ? '0 : mask_next;
    end

    // Retirement map after this cycle's commit; also the restore source for
    // the speculative map on rollback.
    generate
        for (genvar gi = 0; gi < N_AR; gi++) begin : g_ret_next
            assign ret_map_next[gi] = (cm_fire && (cm_dest_ar == AR_W'(gi)))
                                      ? cm_dest_pr : ret_map_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_AR; i++) begin
                spec_map_reg[i] <= '0;
                ret_map_reg[i]  <= '0;
            end
            inflight_reg     <= '0;
            out_valid_reg    <= 1'b0;
            out_has_dest_reg <= 1'b0;
            out_dest_pr_reg  <= '0;
            out_old_pr_reg   <= '0;
            out_src1_pr_reg  <= '0;
            out_src2_pr_reg  <= '0;
        end else begin
            ret_map_reg <= ret_map_next;
            if (rollback) begin
                spec_map_reg  <= ret_map_next;
                inflight_reg  <= '0;
                out_valid_reg <= 1'b0;
            end else begin
                if (cm_fire) begin
                    inflight_reg[cm_dest_pr] <= 1'b0;
                end
                if (alloc) begin
                    spec_map_reg[in_dest_ar]    <= fl_dequeue_pr;
                    inflight_reg[fl_dequeue_pr] <= 1'b1;
                end
                if (accept) begin
                    // Lookups use the map before this instruction's own update.
                    out_valid_reg    <= 1'b1;
                    out_has_dest_reg <= alloc;
                    out_dest_pr_reg  <= alloc ? fl_dequeue_pr : '0;
                    out_old_pr_reg   <= alloc ? spec_map_reg[in_dest_ar] : '0;
                    out_src1_pr_reg  <= spec_map_reg[in_src1_ar];
                    out_src2_pr_reg  <= spec_map_reg[in_src2_ar];
                end else if (out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_has_dest = out_has_dest_reg;
    assign out_dest_pr  = out_dest_pr_reg;
    assign out_old_pr   = out_old_pr_reg;
    assign out_src1_pr  = out_src1_pr_reg;
    assign out_src2_pr  = out_src2_pr_reg;

endmodule

// File: tb/tb_rename_map.sv
// tb_rename_map: directed plus randomized test of rename_map. The bench plays
// the free list (a queue of free PRs) and a simple in-order reorder buffer
// (a queue of renamed destinations awaiting commit), and predicts every DUT
// output from the rename/commit/rollback rules using plain arrays.
module tb_rename_map;
    localparam int N_AR = 32;
    localparam int N_PR = 64;

    logic       clk;
    logic       reset;
    logic       in_valid, in_ready, in_has_dest;
    logic [4:0] in_dest_ar, in_src1_ar, in_src2_ar;
    logic       out_valid, out_ready, out_has_dest;
    logic [5:0] out_dest_pr, out_old_pr, out_src1_pr, out_src2_pr;
    logic       cm_valid, cm_has_dest;
    logic [4:0] cm_dest_ar;
    logic [5:0] cm_dest_pr;
    logic       rollback, fl_is_empty;
    logic [5:0] fl_dequeue_pr;
    logic       fl_dequeue_en, fl_enqueue_en, fl_rollback;
    logic [5:0] fl_enqueue_pr;
    logic [63:0] fl_rollback_mask;

    rename_map #(.N_AR(N_AR), .N_PR(N_PR)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_has_dest(in_has_dest),
        .in_dest_ar(in_dest_ar), .in_src1_ar(in_src1_ar), .in_src2_ar(in_src2_ar),
        .out_valid(out_valid), .out_ready(out_ready), .out_has_dest(out_has_dest),
        .out_dest_pr(out_dest_pr), .out_old_pr(out_old_pr),
        .out_src1_pr(out_src1_pr), .out_src2_pr(out_src2_pr),
        .cm_valid(cm_valid), .cm_has_dest(cm_has_dest),
        .cm_dest_ar(cm_dest_ar), .cm_dest_pr(cm_dest_pr),
        .rollback(rollback), .fl_is_empty(fl_is_empty), .fl_dequeue_pr(fl_dequeue_pr),
        .fl_dequeue_en(fl_dequeue_en), .fl_enqueue_en(fl_enqueue_en),
        .fl_enqueue_pr(fl_enqueue_pr), .fl_rollback(fl_rollback),
        .fl_rollback_mask(fl_rollback_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int ar; int pr; } rob_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_spec [N_AR];
    int   m_ret  [N_AR];
    bit   m_inf  [N_PR];
    bit   m_ov;
    int   e_hd, e_dest, e_old, e_s1, e_s2;
    int   fl_q [$];
    rob_t rob [$];
    logic        obs_ready, obs_deq, obs_enq;
    logic [5:0]  obs_enq_pr;
    logic [63:0] obs_mask;
    int   saved_pr, saved_dest;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_AR; i++) begin
            m_spec[i] = 0;
            m_ret[i]  = 0;
        end
        for (int p = 0; p < N_PR; p++) m_inf[p] = 1'b0;
        m_ov = 1'b0;
        rob.delete();
        fl_q.delete();
        for (int p = 5; p < N_PR; p++) fl_q.push_back(p);
        for (int p = 1; p < 5; p++) fl_q.push_back(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1; in_has_dest = 1'b1; in_dest_ar = 5'd3;
        in_src1_ar = 5'd1; in_src2_ar = 5'd2; out_ready = 1'b1;
        cm_valid = 1'b1; cm_has_dest = 1'b1; cm_dest_ar = 5'd3; cm_dest_pr = 6'd9;
        rollback = 1'b1; fl_is_empty = 1'b0; fl_dequeue_pr = 6'd5;
        #1;
        chk("rst_deq_en", 64'(fl_dequeue_en), 64'd0);
        chk("rst_enq_en", 64'(fl_enqueue_en), 64'd0);
        chk("rst_fl_rollback", 64'(fl_rollback), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_dest", 64'(out_dest_pr), 64'd0);
        chk("rst_out_src1", 64'(out_src1_pr), 64'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; cm_valid = 1'b0; rollback = 1'b0;
        model_reset();
    endtask

    // One cycle: cm = 0 none, 1 commit ROB head, 2 commit without destination.
    task automatic step(input int iv, input int ih, input int dar, input int s1, input int s2,
                        input int ordy, input int cm, input int rb, input int fe);
        bit cmv, cmh, fire, e_enq, empty, e_rdy, acc, e_alloc;
        int car, cpr, old, newpr;
        logic [63:0] e_mask;
        @(negedge clk);
        cmv = 0; cmh = 0;
        car = $urandom_range(0, 31); cpr = $urandom_range(0, 63);
        if (cm == 1 && rob.size() > 0) begin
            cmv = 1; cmh = 1; car = rob[0].ar; cpr = rob[0].pr;
        end else if (cm == 2) begin
            cmv = 1;
        end
        fire  = cmv && cmh && car != 0;
        old   = fire ? m_ret[car] : 0;
        e_enq = fire && old != 0 && rb == 0;
        empty = fe != 0 || fl_q.size() == 0;
        e_rdy = (!m_ov || ordy != 0) && rb == 0 && (!empty || e_enq);
        acc   = iv != 0 && e_rdy;
        e_alloc = acc && ih != 0 && dar != 0;
        newpr = empty ? (e_enq ? old : 0) : fl_q[0];
        for (int p = 0; p < N_PR; p++) e_mask[p] = m_inf[p];
        if (fire) begin
            e_mask[cpr] = 1'b0;
            if (old != 0) e_mask[old] = 1'b1;
        end

        in_valid = iv[0]; in_has_dest = ih[0]; in_dest_ar = 5'(dar);
        in_src1_ar = 5'(s1); in_src2_ar = 5'(s2); out_ready = ordy[0];
        cm_valid = cmv; cm_has_dest = cmh; cm_dest_ar = 5'(car); cm_dest_pr = 6'(cpr);
        rollback = rb[0]; fl_is_empty = empty; fl_dequeue_pr = 6'(newpr);
        #1;
        obs_ready = in_ready; obs_deq = fl_dequeue_en; obs_enq = fl_enqueue_en;
        obs_enq_pr = fl_enqueue_pr; obs_mask = fl_rollback_mask;
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("fl_dequeue_en", 64'(fl_dequeue_en), 64'(e_alloc));
        chk("fl_enqueue_en", 64'(fl_enqueue_en), 64'(e_enq));
        if (e_enq) chk("fl_enqueue_pr", 64'(fl_enqueue_pr), 64'(old));
        chk("fl_rollback", 64'(fl_rollback), 64'(rb));
        if (rb != 0) chk("fl_rollback_mask", fl_rollback_mask, e_mask);

        @(posedge clk);
        if (fire) m_ret[car] = cpr;
        if (cmv && cmh) void'(rob.pop_front());
        if (rb != 0) begin
            m_spec = m_ret;
            for (int p = 0; p < N_PR; p++) m_inf[p] = 1'b0;
            m_ov = 1'b0;
            rob.delete();
            fl_q.delete();
            for (int p = 1; p < N_PR; p++) begin
                bit used = 1'b0;
                for (int a = 0; a < N_AR; a++) if (m_ret[a] == p) used = 1'b1;
                if (!used) fl_q.push_back(p);
            end
        end else begin
            if (fire) m_inf[cpr] = 1'b0;
            if (empty) begin
                if (e_enq && !e_alloc) fl_q.push_back(old);
            end else begin
                if (e_alloc) void'(fl_q.pop_front());
                if (e_enq) fl_q.push_back(old);
            end
            if (acc) begin
                m_ov = 1'b1;
                e_hd = e_alloc; e_dest = e_alloc ? newpr : 0;
                e_old = e_alloc ? m_spec[dar] : 0;
                e_s1 = m_spec[s1]; e_s2 = m_spec[s2];
                if (e_alloc) begin
                    m_spec[dar] = newpr;
                    m_inf[newpr] = 1'b1;
                    rob.push_back('{dar, newpr});
                end
            end else if (ordy != 0) begin
                m_ov = 1'b0;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_has_dest", 64'(out_has_dest), 64'(e_hd));
            chk("out_dest_pr", 64'(out_dest_pr), 64'(e_dest));
            chk("out_src1_pr", 64'(out_src1_pr), 64'(e_s1));
            chk("out_src2_pr", 64'(out_src2_pr), 64'(e_s2));
            if (e_hd != 0) chk("out_old_pr", 64'(out_old_pr), 64'(e_old));
        end
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        do_reset();

        // r3 <= r1,r2 ; r4 <= r3,r3 ; r3 <= r3
        step(1, 1, 3, 1, 2, 1, 0, 0, 0);
        chk("add_dest", 64'(out_dest_pr), 64'd5);
        chk("add_old", 64'(out_old_pr), 64'd0);
        chk("add_src1", 64'(out_src1_pr), 64'd0);
        step(1, 1, 4, 3, 3, 1, 0, 0, 0);
        chk("dep_src1", 64'(out_src1_pr), 64'd5);
        chk("dep_src2", 64'(out_src2_pr), 64'd5);
        chk("dep_dest", 64'(out_dest_pr), 64'd6);
        step(1, 1, 3, 3, 0, 1, 0, 0, 0);
        chk("self_src1", 64'(out_src1_pr), 64'd5);
        chk("self_old", 64'(out_old_pr), 64'd5);
        chk("self_dest", 64'(out_dest_pr), 64'd7);

        // rollback with same-cycle commit r3<-5
        step(0, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("rb_mask_67", obs_mask, 64'h00000000000000C0);
        chk("rb_out_valid", 64'(out_valid), 64'd0);
        step(1, 0, 0, 3, 0, 1, 0, 0, 0);
        chk("rb_spec_r3", 64'(out_src1_pr), 64'd5);

        // empty free list, then passthrough
        step(1, 1, 2, 1, 1, 1, 0, 0, 0);
        saved_pr = int'(out_dest_pr);
        step(1, 1, 2, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 2, 1, 0, 0, 1);
        chk("empty_ready", 64'(obs_ready), 64'd0);
        chk("empty_deq", 64'(obs_deq), 64'd0);
        step(1, 1, 6, 1, 2, 1, 1, 0, 1);
        chk("pass_enq", 64'(obs_enq), 64'd1);
        chk("pass_enq_pr", 64'(obs_enq_pr), 64'(saved_pr));
        chk("pass_ready", 64'(obs_ready), 64'd1);
        chk("pass_dest", 64'(out_dest_pr), 64'(saved_pr));

        // downstream stall for three cycles, then release
        saved_dest = int'(out_dest_pr);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 7, 1, 1, 0, 0, 0, 0);
            chk("stall_ready", 64'(obs_ready), 64'd0);
            chk("stall_deq", 64'(obs_deq), 64'd0);
            chk("stall_dest", 64'(out_dest_pr), 64'(saved_dest));
        end
        step(1, 1, 7, 1, 1, 1, 0, 0, 0);
        chk("release_ready", 64'(obs_ready), 64'd1);

        // destination r0 is never renamed
        step(1, 1, 0, 1, 0, 1, 0, 0, 0);
        chk("r0_deq", 64'(obs_deq), 64'd0);
        chk("r0_has_dest", 64'(out_has_dest), 64'd0);
        chk("r0_dest", 64'(out_dest_pr), 64'd0);

        // reset mid-stream clears the maps
        step(1, 1, 9, 3, 4, 1, 1, 0, 0);
        do_reset();
        step(1, 0, 0, 3, 7, 1, 0, 0, 0);
        chk("post_rst_src1", 64'(out_src1_pr), 64'd0);
        chk("post_rst_src2", 64'(out_src2_pr), 64'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 4) != 0, ($urandom % 4) != 0, $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), ($urandom % 4) != 0,
                 $urandom_range(0, 2), ($urandom % 25) == 0, ($urandom % 10) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
